// File: rtl/ibex_sec_erase_ctrl.sv
// rtl/ibex_sec_erase_ctrl.sv - erase-strobe sequencer and bitwise-logic first-cycle flag
// Strobes registers named by an accepted mask in bulk or in capped groups, lowest index first.
module ibex_sec_erase_ctrl #(
    parameter bit          RV32E       = 1'b0,
    parameter int unsigned ErsPerCycle = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_mask_i,
    input  logic        req_seq_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] sec_ers_o,
    input  logic        bw_start_i,
    output logic        sec_bwlogic_first_cycle_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        ERASE = 1'b1
    } state_e;

    localparam logic [5:0]  EpcLimit = 6'(ErsPerCycle);
    localparam logic [31:0] RegMask  = RV32E ? 32'h0000_FFFE : 32'hFFFF_FFFE;

    state_e      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic        mode_q, mode_d;
    logic        done_q, done_d;
    logic        flag_q, flag_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic [31:0] sel;
    logic [5:0]  sel_cnt;

    // Sequential mode takes the lowest set bits of pending, up to the per-cycle cap.
    always_comb begin
        sel     = 32'h0;
        sel_cnt = 6'd0;
        if (state_q == ERASE) begin
            if (!mode_q) begin
                sel = pending_q;
            end else begin
                for (int i = 0; i < 32; i++) begin
                    if (pending_q[i] && (sel_cnt < EpcLimit)) begin
                        sel[i]  = 1'b1;
                        sel_cnt = sel_cnt + 6'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        flag_d    = bw_start_i & ~flag_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    pending_d = req_mask_i & RegMask;
                    mode_d    = req_seq_i;
                    state_d   = ERASE;
                end
            end
            ERASE: begin
                pending_d = pending_q & ~sel;
                if (pending_d == 32'h0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == ERASE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= 32'h0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            flag_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            flag_q    <= flag_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign req_ready_o               = ready_q;
    assign busy_o                    = busy_q;
    assign done_o                    = done_q;
    assign sec_ers_o                 = sel;
    assign sec_bwlogic_first_cycle_o = flag_q;

endmodule

// File: tb/tb_ibex_sec_erase_ctrl.sv
// tb/tb_ibex_sec_erase_ctrl.sv - directed self-checking bench for ibex_sec_erase_ctrl
module tb_ibex_sec_erase_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_mask;
    logic        req_seq;
    logic        bw_start;

    logic        ready, busy, done, flag;
    logic [31:0] ers;
    logic        ready_e, busy_e, done_e, flag_e;
    logic [31:0] ers_e;

    int checks   = 0;
    int failures = 0;

    ibex_sec_erase_ctrl #(.RV32E(1'b0), .ErsPerCycle(4)) dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .req_valid_i               (req_valid),
        .req_ready_o               (ready),
        .req_mask_i                (req_mask),
        .req_seq_i                 (req_seq),
        .busy_o                    (busy),
        .done_o                    (done),
        .sec_ers_o                 (ers),
        .bw_start_i                (bw_start),
        .sec_bwlogic_first_cycle_o (flag)
    );

    ibex_sec_erase_ctrl #(.RV32E(1'b1), .ErsPerCycle(4)) dut_e (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .req_valid_i               (req_valid),
        .req_ready_o               (ready_e),
        .req_mask_i                (req_mask),
        .req_seq_i                 (req_seq),
        .busy_o                    (busy_e),
        .done_o                    (done_e),
        .sec_ers_o                 (ers_e),
        .bw_start_i                (bw_start),
        .sec_bwlogic_first_cycle_o (flag_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_mask  = 32'h0;
        req_seq   = 1'b0;
        bw_start  = 1'b0;
        step();
        step();
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ers", ers, 32'h0);
        check("rst_flag", 32'(flag), 32'h0);
        rst = 1'b0;
        step();

        // Bulk
        req_valid = 1'b1; req_mask = 32'h8000_0006; req_seq = 1'b0;
        step();
        req_valid = 1'b0;
        check("bulk_ers", ers, 32'h8000_0006);
        check("bulk_busy", 32'(busy), 32'h1);
        check("bulk_ready_lo", 32'(ready), 32'h0);
        check("bulk_done_lo", 32'(done), 32'h0);
        step();
        check("bulk_done", 32'(done), 32'h1);
        check("bulk_ready", 32'(ready), 32'h1);
        check("bulk_ers_after", ers, 32'h0);
        step();
        check("bulk_done_pulse", 32'(done), 32'h0);

        // Sequential, 4 per cycle
        req_valid = 1'b1; req_mask = 32'h0000_03FE; req_seq = 1'b1;
        step();
        req_valid = 1'b0;
        check("seq_ers0", ers, 32'h0000_001E);
        step();
        check("seq_ers1", ers, 32'h0000_01E0);
        check("seq_done_lo", 32'(done), 32'h0);
        step();
        check("seq_ers2", ers, 32'h0000_0200);
        step();
        check("seq_done", 32'(done), 32'h1);
        check("seq_ers_after", ers, 32'h0);

        // Masking: all ones, bulk, both variants
        req_valid = 1'b1; req_mask = 32'hFFFF_FFFF; req_seq = 1'b0;
        step();
        req_valid = 1'b0;
        check("mask_rv32e_ers", ers_e, 32'h0000_FFFE);
        check("mask_rv32i_ers", ers, 32'hFFFF_FFFE);
        step();
        check("mask_rv32e_done", 32'(done_e), 32'h1);

        // Only bit 0: empty erase cycle
        req_valid = 1'b1; req_mask = 32'h0000_0001; req_seq = 1'b1;
        step();
        req_valid = 1'b0;
        check("empty_ers", ers, 32'h0);
        check("empty_busy", 32'(busy), 32'h1);
        step();
        check("empty_done", 32'(done), 32'h1);

        // Handshake: valid held through ERASE with a different mask
        req_valid = 1'b1; req_mask = 32'h0000_03FE; req_seq = 1'b1;
        step();
        req_mask = 32'h0000_0100; req_seq = 1'b0;
        check("hs_ers0", ers, 32'h0000_001E);
        step();
        check("hs_ers1", ers, 32'h0000_01E0);
        step();
        check("hs_ers2", ers, 32'h0000_0200);
        step();
        check("hs_done", 32'(done), 32'h1);
        check("hs_ready", 32'(ready), 32'h1);
        check("hs_ers_idle", ers, 32'h0);
        step();
        req_valid = 1'b0;
        check("hs_second_ers", ers, 32'h0000_0100);
        check("hs_second_busy", 32'(busy), 32'h1);
        step();
        check("hs_second_done", 32'(done), 32'h1);

        // Reset during the second strobe cycle
        req_valid = 1'b1; req_mask = 32'hFFFF_FFFE; req_seq = 1'b1;
        step();
        req_valid = 1'b0;
        check("rm_ers0", ers, 32'h0000_001E);
        step();
        check("rm_ers1", ers, 32'h0000_01E0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rm_ers", ers, 32'h0);
        check("rm_busy", 32'(busy), 32'h0);
        check("rm_ready", 32'(ready), 32'h1);
        check("rm_done", 32'(done), 32'h0);
        step();
        check("rm_done_later", 32'(done), 32'h0);
        check("rm_ers_later", ers, 32'h0);
        req_valid = 1'b1; req_mask = 32'h0000_0030; req_seq = 1'b1;
        step();
        req_valid = 1'b0;
        check("rm_next_ers", ers, 32'h0000_0030);
        step();
        check("rm_next_done", 32'(done), 32'h1);

        // Bitwise-logic flag
        bw_start = 1'b1;
        step();
        check("flag_c1", 32'(flag), 32'h1);
        step();
        check("flag_c2", 32'(flag), 32'h0);
        step();
        check("flag_c3", 32'(flag), 32'h1);
        bw_start = 1'b0;
        step();
        check("flag_c4", 32'(flag), 32'h0);
        bw_start = 1'b1;
        step();
        bw_start = 1'b0;
        check("flag_pulse", 32'(flag), 32'h1);
        step();
        check("flag_pulse_end", 32'(flag), 32'h0);
        step();
        check("flag_pulse_idle", 32'(flag), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
